// File: rtl/jtkcpu_pshpul_pkg.sv
// Shared jtkcpu push/pull definitions: register indices as they appear in
// the PSHS/PULS postbyte, the set of 16-bit registers, and the sequencer
// state encoding.
package jtkcpu_pshpul_pkg;

  // Postbyte bit numbers; also the register-file select index.
  localparam logic [2:0] REG_CC = 3'd0;
  localparam logic [2:0] REG_A  = 3'd1;
  localparam logic [2:0] REG_B  = 3'd2;
  localparam logic [2:0] REG_DP = 3'd3;
  localparam logic [2:0] REG_X  = 3'd4;
  localparam logic [2:0] REG_Y  = 3'd5;
  localparam logic [2:0] REG_U  = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  // X, Y, U and PC are 16-bit; the rest are 8-bit.
  localparam logic [7:0] MASK_16B  = 8'hF0;

  // Effective masks used on interrupt entry.
  localparam logic [7:0] MASK_ALL  = 8'hFF;
  localparam logic [7:0] MASK_FIRQ = 8'h81;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    XFER_HI = 2'd2,
    FIN     = 2'd3
  } pshpul_state_t;

  function automatic logic is_16b(input logic [2:0] idx);
    return MASK_16B[idx];
  endfunction

endpackage

// File: rtl/jtkcpu_pshpul_enc.sv
// Next-register priority encoder for push/pull sequencing.
// Push (pul=0) serves the highest pending bit, pull (pul=1) the lowest.
module jtkcpu_pshpul_enc (
  input  logic [7:0] mask,
  input  logic       pul,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan order makes the last match win: descending for pull, ascending for push.
  always_comb begin
    idx   = 3'd0;
    valid = |mask;
    if (pul) begin
      for (int i = 7; i >= 0; i--) begin
        if (mask[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// jtkcpu push/pull sequencer: walks a register mask, one memory transfer
// per register, and returns the updated stack pointer.
// Optional feature: define JTKCPU_FIRQ_FAST_EN so FIRQ entry stacks only
// PC and CC (mask 8'h81); otherwise every interrupt entry stacks all.
//
// Handshake: all state moves on cen. start is sampled only in IDLE; while
// psh_en is high the memory controller performs the transfer at psh_addr
// (write if wrq) and a 16-bit transfer spans two cen periods. ld, sp_we
// and done are level outputs lasting exactly one cen period.
module jtkcpu_pshpul
  import jtkcpu_pshpul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic        pul,
  input  logic [7:0]  mask,
  input  logic        int_frame,
  input  logic        firq,
  input  logic [15:0] sp_in,
  output logic [15:0] psh_addr,
  output logic        psh_en,
  output logic        mem16,
  output logic        wrq,
  output logic [2:0]  sel,
  output logic        ld,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        done,
  output logic        active
);

  pshpul_state_t state, st_nxt;
  logic [7:0]    msk, msk_nxt;
  logic          pul_r, pul_nxt;
  logic [15:0]   sp, sp_nxt;

  logic [2:0]    idx;
  logic          idx_valid;
  logic [7:0]    eff_mask;
  logic          cur16;
  logic [15:0]   width;
  logic          in_xfer;
  logic          last;

  jtkcpu_pshpul_enc u_enc (
    .mask  (msk),
    .pul   (pul_r),
    .idx   (idx),
    .valid (idx_valid)
  );

`ifdef JTKCPU_FIRQ_FAST_EN
  // Interrupt entry overrides the postbyte; fast FIRQ stacks only PC and CC.
  always_comb begin
    eff_mask = mask;
    if (int_frame) eff_mask = firq ? MASK_FIRQ : MASK_ALL;
  end
`else
  logic unused_firq;
  assign unused_firq = firq;

  // Interrupt entry overrides the postbyte with the full register set.
  always_comb begin
    eff_mask = mask;
    if (int_frame) eff_mask = MASK_ALL;
  end
`endif

  assign cur16   = is_16b(idx);
  assign width   = cur16 ? 16'd2 : 16'd1;
  assign in_xfer = (state == XFER) || (state == XFER_HI);
  assign last    = ((state == XFER) && !cur16) || (state == XFER_HI);

  // Sequencer registers; everything advances on cen only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      msk   <= 8'd0;
      pul_r <= 1'b0;
      sp    <= 16'd0;
    end else if (cen) begin
      state <= st_nxt;
      msk   <= msk_nxt;
      pul_r <= pul_nxt;
      sp    <= sp_nxt;
    end
  end

  // Next state: latch on start, retire one register at the end of each
  // transfer (clear its bit, move sp), finish when the mask runs out.
  always_comb begin
    st_nxt  = state;
    msk_nxt = msk;
    pul_nxt = pul_r;
    sp_nxt  = sp;
    case (state)
      IDLE: begin
        if (start) begin
          msk_nxt = eff_mask;
          pul_nxt = pul;
          sp_nxt  = sp_in;
          st_nxt  = (|eff_mask) ? XFER : FIN;
        end
      end
      XFER, XFER_HI: begin
        if (state == XFER && cur16) begin
          st_nxt = XFER_HI;
        end else begin
          msk_nxt = msk & ~(8'd1 << idx);
          sp_nxt  = pul_r ? sp + width : sp - width;
          st_nxt  = (|msk_nxt && idx_valid) ? XFER : FIN;
        end
      end
      FIN:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Outputs decode from the registered state so reset clears them at once.
  // Push addresses the pre-decremented sp; pull addresses the current sp.
  always_comb begin
    psh_en   = in_xfer;
    mem16    = in_xfer && cur16;
    wrq      = in_xfer && !pul_r;
    sel      = in_xfer ? idx : 3'd0;
    psh_addr = in_xfer ? (pul_r ? sp : sp - width) : 16'd0;
    ld       = last && pul_r;
    sp_out   = sp;
    sp_we    = (state == FIN);
    done     = (state == FIN);
    active   = (state != IDLE);
  end

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Bench for jtkcpu_pshpul: a vector table of push/pull sequences plus
// hand-written reset-abort and restart-while-active sequences. A reference
// model queues the expected bus activity per cen period.
module tb_jtkcpu_pshpul;

  localparam int W = 22; // {wrq, mem16, sel[2:0], ld, addr[15:0]}

  logic        clk = 1'b0;
  logic        rst, cen, start, pul, int_frame, firq;
  logic [7:0]  mask;
  logic [15:0] sp_in;
  logic [15:0] psh_addr, sp_out;
  logic        psh_en, mem16, wrq, ld, sp_we, done, active;
  logic [2:0]  sel;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        pul;
    logic [7:0]  mask;
    logic        intf;
    logic        firq;
    logic [15:0] sp;
    logic [15:0] exp_sp;
    int          exp_lat; // cen periods from start to the done period; <0: take from model
  } vec_t;

  vec_t vt[12];

  jtkcpu_pshpul dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .pul(pul), .mask(mask),
    .int_frame(int_frame), .firq(firq), .sp_in(sp_in), .psh_addr(psh_addr),
    .psh_en(psh_en), .mem16(mem16), .wrq(wrq), .sel(sel), .ld(ld),
    .sp_out(sp_out), .sp_we(sp_we), .done(done), .active(active)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] m, input logic i, input logic f);
    if (!i) return m;
`ifdef JTKCPU_FIRQ_FAST_EN
    if (f) return 8'h81;
`endif
    return 8'hFF;
  endfunction

  // Reference model: one queue entry per cen period with psh_en high.
  task automatic model(input logic p, input logic [7:0] m, input logic [15:0] s,
                       output logic [15:0] sf, output int lat);
    logic [15:0] a;
    a   = s;
    lat = 1;
    if (!p) begin
      for (int b = 7; b >= 0; b--) begin
        if (m[b]) begin
          if (b >= 4) begin
            a = a - 16'd2;
            exp_q.push_back({1'b1, 1'b1, 3'(b), 1'b0, a});
            exp_q.push_back({1'b1, 1'b1, 3'(b), 1'b0, a});
            lat += 2;
          end else begin
            a = a - 16'd1;
            exp_q.push_back({1'b1, 1'b0, 3'(b), 1'b0, a});
            lat += 1;
          end
        end
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) begin
          if (b >= 4) begin
            exp_q.push_back({1'b0, 1'b1, 3'(b), 1'b0, a});
            exp_q.push_back({1'b0, 1'b1, 3'(b), 1'b1, a});
            a = a + 16'd2;
            lat += 2;
          end else begin
            exp_q.push_back({1'b0, 1'b0, 3'(b), 1'b1, a});
            a = a + 16'd1;
            lat += 1;
          end
        end
      end
    end
    sf = a;
  endtask

  // One cen period: cen high for one clk, low for the next. Called at negedge.
  task automatic tick(input logic glitch);
    cen = 1'b1;
    if (glitch) begin
      start = 1'b1;
      pul   = ~pul;
      mask  = 8'hFF;
      sp_in = 16'hAAAA;
    end
    @(negedge clk);
    cen   = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_seq(input vec_t v, input logic glitch);
    logic [15:0] msp;
    int          mlat, lat, want_lat;
    logic [15:0] want_sp;
    logic        got_done;
    exp_q.delete();
    model(v.pul, eff(v.mask, v.intf, v.firq), v.sp, msp, mlat);
    want_sp  = (v.exp_lat < 0) ? msp : v.exp_sp;
    want_lat = (v.exp_lat < 0) ? mlat : v.exp_lat;
    pul = v.pul; mask = v.mask; int_frame = v.intf; firq = v.firq; sp_in = v.sp;
    start = 1'b1;
    tick(1'b0);
    int_frame = 1'b0;
    lat = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      lat++;
      chk("active", {31'd0, active}, 32'd1);
      if (psh_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL xfer_extra: got addr %h sel %0d, want none", psh_addr, sel);
        end else begin
          chk("xfer", {10'd0, wrq, mem16, sel, ld, psh_addr}, {10'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        got_done = 1'b1;
        chk("latency", lat, want_lat);
        chk("sp_out", {16'd0, sp_out}, {16'd0, want_sp});
        chk("sp_we", {31'd0, sp_we}, 32'd1);
        chk("fin_bus", {29'd0, psh_en, mem16, wrq}, 32'd0);
      end
      tick(glitch && !got_done);
    end
    if (!got_done) begin
      total++; bad++;
      $display("FAIL timeout: got no done, want done after %0d cen", want_lat);
    end
    chk("idle_after", {30'd0, active, done}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // reset
    rst = 1'b1; cen = 1'b0; start = 1'b0; pul = 1'b0; mask = 8'h00;
    int_frame = 1'b0; firq = 1'b0; sp_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_outs", {21'd0, psh_en, mem16, wrq, sel, ld, sp_we, done, active}, 32'd0);
    chk("rst_addr_sp", {psh_addr, sp_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //        pul  mask   intf firq sp        exp_sp    lat
    vt[0]  = '{1'b0, 8'h06, 1'b0, 1'b0, 16'h1000, 16'h0FFE, 3};
    vt[1]  = '{1'b1, 8'h90, 1'b0, 1'b0, 16'h0F00, 16'h0F04, 5};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 16'h1234, 1};
    vt[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 16'h4321, 16'h4321, 1};
`ifdef JTKCPU_FIRQ_FAST_EN
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h0001, 16'hFFFE, 4};
`else
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h0001, 16'hFFF5, 13};
`endif
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h8000, 16'h7FF4, 13};
    vt[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 16'h7FF4, 16'h8000, 13};
    vt[7]  = '{1'b0, 8'h81, 1'b0, 1'b1, 16'h0500, 16'h04FD, 4};
    vt[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 2};
    vt[9]  = '{1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 3};
    for (int r = 10; r < 12; r++) begin
      vt[r] = '{1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b0,
                16'($urandom_range(0, 65535)), 16'h0000, -1};
    end
    for (int i = 0; i < 12; i++) run_seq(vt[i], 1'b0);

    // start re-asserted while active is ignored
    run_seq(vt[0], 1'b1);
    run_seq(vt[1], 1'b1);

    // reset during the second transfer of a full push
    pul = 1'b0; mask = 8'hFF; sp_in = 16'h2000; start = 1'b1;
    tick(1'b0);
    chk("abort_pc", {12'd0, psh_en, sel, psh_addr}, {12'd0, 1'b1, 3'd7, 16'h1FFE});
    tick(1'b0);
    tick(1'b0);
    chk("abort_u", {12'd0, psh_en, sel, psh_addr}, {12'd0, 1'b1, 3'd6, 16'h1FFC});
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {21'd0, psh_en, mem16, wrq, sel, ld, sp_we, done, active}, 32'd0);
    chk("abort_addr_sp", {psh_addr, sp_out}, 32'd0);
    @(negedge clk);
    tick(1'b0);
    chk("abort_no_done", {30'd0, done, sp_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {31'd0, active}, 32'd0);
    run_seq(vt[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
